// File: rtl/addr_gen_unit.sv
// addr_gen_unit: registered address generator (direct, base-relative, circular, bit-reversed) with base/len/idx registers
module addr_gen_unit #(
  parameter int MDATAW = 8,
  parameter int FFTSIZ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        mode,
  input  logic [MDATAW-1:0] addr,
  input  logic [MDATAW-1:0] in,
  input  logic              ld_base,
  input  logic              ld_len,
  input  logic              clr_idx,
  output logic [MDATAW-1:0] out,
  output logic              valid
);
  localparam logic [MDATAW-1:0] msk = {MDATAW{1'b1}} >> (MDATAW - FFTSIZ);
  logic [MDATAW-1:0] base_r, len_r, idx_r, rev, gen, idx_n;
  logic [MDATAW:0]   inc;
  always_comb begin
    rev = '0;
    for (int i = 0; i < FFTSIZ; i++) rev[i] = idx_r[FFTSIZ-1-i];
  end
  assign inc = {1'b0, idx_r} + (MDATAW+1)'(1);
  assign gen = mode == 2'd0 ? addr : base_r + (mode == 2'd1 ? addr : mode == 2'd2 ? idx_r : rev);
  assign idx_n = (clr_idx || ld_len) ? '0 :
                 !req ? idx_r :
                 mode == 2'd2 ? ((len_r != '0 && inc >= {1'b0, len_r}) ? '0 : inc[MDATAW-1:0]) :
                 mode == 2'd3 ? (inc[MDATAW-1:0] & msk) : idx_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0;
      len_r  <= '0;
      idx_r  <= '0;
      out    <= '0;
      valid  <= 1'b0;
    end else begin
      if (req) out <= gen;
      valid <= req;
      if (ld_base) base_r <= in;
      if (ld_len) len_r <= in;
      idx_r <= idx_n;
    end
  end
endmodule

// File: tb/tb_addr_gen_unit.sv
// tb_addr_gen_unit: directed and randomized self-checking bench for addr_gen_unit against a behavioural model
module tb_addr_gen_unit;
  logic       clk = 1'b0;
  logic       rst, req, ld_base, ld_len, clr_idx;
  logic [1:0] mode;
  logic [7:0] addr, in, out;
  logic       valid;
  int checks = 0;
  int errors = 0;
  int m_base, m_len, m_idx, m_out, m_valid;

  addr_gen_unit #(.MDATAW(8), .FFTSIZ(3)) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .addr(addr), .in(in),
    .ld_base(ld_base), .ld_len(ld_len), .clr_idx(clr_idx), .out(out), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic int rev3(input int x);
    int r = 0;
    for (int j = 0; j < 3; j++) if (((x >> j) & 1) == 1) r += 1 << (2 - j);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rs, input bit r, input int m, input int a, input int d,
                     input bit lb, input bit ll, input bit cl);
    rst = rs; req = r; mode = 2'(m); addr = 8'(a); in = 8'(d);
    ld_base = lb; ld_len = ll; clr_idx = cl;
    @(posedge clk);
    if (rs) begin
      m_base = 0; m_len = 0; m_idx = 0; m_out = 0; m_valid = 0;
    end else begin
      m_valid = r;
      if (r) begin
        case (m)
          0: m_out = a;
          1: m_out = (m_base + a) % 256;
          2: m_out = (m_base + m_idx) % 256;
          default: m_out = (m_base + rev3(m_idx % 8)) % 256;
        endcase
        if (m == 2) m_idx = (m_len == 0) ? (m_idx + 1) % 256 : (m_idx + 1 >= m_len ? 0 : m_idx + 1);
        if (m == 3) m_idx = (m_idx % 8 + 1) % 8;
      end
      if (lb) m_base = d;
      if (ll) begin m_len = d; m_idx = 0; end
      if (cl) m_idx = 0;
    end
    #1;
    chk("model_out", 32'(out), 32'(m_out));
    chk("model_valid", 32'(valid), 32'(m_valid));
  endtask

  initial begin
    int exp34 [9] = '{8'h40, 8'h44, 8'h42, 8'h46, 8'h41, 8'h45, 8'h43, 8'h47, 8'h40};
    int exp33 [4] = '{8'h10, 8'h11, 8'h12, 8'h10};
    cyc(1, 1, 2, 0, 0, 1, 1, 1);
    chk("reset_out", 32'(out), 0);
    chk("reset_valid", 32'(valid), 0);
    cyc(0, 0, 0, 0, 8'hF0, 1, 0, 0);
    cyc(0, 1, 1, 8'h20, 0, 0, 0, 0);
    chk("rel_wrap_out", 32'(out), 8'h10);
    chk("rel_wrap_valid", 32'(valid), 1);
    cyc(0, 0, 1, 8'h33, 0, 0, 0, 0);
    chk("idle_valid", 32'(valid), 0);
    chk("idle_hold", 32'(out), 8'h10);
    cyc(0, 0, 0, 0, 8'h10, 1, 0, 0);
    cyc(0, 0, 0, 0, 3, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2, 0, 0, 0, 0, 0);
      chk($sformatf("circ_%0d", i), 32'(out), 32'(exp33[i]));
    end
    cyc(0, 0, 0, 0, 8'h40, 1, 0, 1);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 3, 0, 0, 0, 0, 0);
      chk($sformatf("bitrev_%0d", i), 32'(out), 32'(exp34[i]));
    end
    cyc(0, 0, 0, 0, 8'h10, 1, 0, 0);
    cyc(0, 1, 1, 1, 8'h80, 1, 0, 0);
    chk("ld_collide_old", 32'(out), 8'h11);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    chk("ld_collide_new", 32'(out), 8'h81);
    cyc(0, 0, 0, 0, 4, 0, 1, 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    chk("pre_rst_out", 32'(out), 8'h81);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    chk("post_rst_req", 32'(out), 0);
    chk("post_rst_valid", 32'(valid), 1);
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 1);
    chk("clr_same_cycle", 32'(out), 8'h02);
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    chk("clr_next", 32'(out), 8'h00);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
          $urandom_range(0, 255), $urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 255),
          $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
